// File: rtl/debounce_bus_scanner_if.sv
// -----------------------------------------------------------------------------
// debounce_bus_scanner_if
// Bus bundle between the debouncer-board scanner and its environment.
//   scan_en    : level, keep scanning while high            (env -> scanner)
//   d_in       : shared data bus of the selected board       (env -> scanner)
//   aBus       : board select, true-polarity address         (scanner -> env)
//   ev_valid   : change event available                      (scanner -> env)
//   ev_ready   : consumer accepts the event                  (env -> scanner)
//   ev_addr    : board index of the event                    (scanner -> env)
//   ev_data    : newly sampled value                         (scanner -> env)
//   ev_mask    : changed bits versus previous snapshot       (scanner -> env)
//   scan_done  : one-cycle pulse when the last board is done (scanner -> env)
//   busy       : scanner is not idle                         (scanner -> env)
// master = scanner side, slave = board/consumer side.
// -----------------------------------------------------------------------------
interface debounce_bus_scanner_if #(
  parameter int DW = 8
) ();
  logic          scan_en;
  logic [DW-1:0] d_in;
  logic [2:0]    aBus;
  logic          ev_valid;
  logic          ev_ready;
  logic [2:0]    ev_addr;
  logic [DW-1:0] ev_data;
  logic [DW-1:0] ev_mask;
  logic          scan_done;
  logic          busy;

  modport master (
    input  scan_en, d_in, ev_ready,
    output aBus, ev_valid, ev_addr, ev_data, ev_mask, scan_done, busy
  );

  modport slave (
    output scan_en, d_in, ev_ready,
    input  aBus, ev_valid, ev_addr, ev_data, ev_mask, scan_done, busy
  );
endinterface

// File: rtl/debounce_bus_scanner.sv
// -----------------------------------------------------------------------------
// debounce_bus_scanner
// Polls NUM_BOARDS debouncer boards over a shared data bus. Each board is
// selected on aBus, held SETTLE cycles, sampled on the last settle cycle and
// compared with the last accepted snapshot for that board. Differences are
// reported as events over a valid/ready handshake; the snapshot only moves
// on acceptance, so an unaccepted change is never lost.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : debounce_bus_scanner_if master modport (select, data, events)
// -----------------------------------------------------------------------------
module debounce_bus_scanner #(
  parameter int NUM_BOARDS = 8,
  parameter int SETTLE     = 4,
  parameter int DW         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  debounce_bus_scanner_if.master bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;
  localparam logic [1:0] ST_REPORT  = 2'd3;

  localparam int             CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [2:0]     LAST_IDX = 3'(NUM_BOARDS - 1);

  logic [1:0]    state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [2:0]    idx_q,       idx_d;
  logic [DW-1:0] sample_q,    sample_d;
  logic          ev_valid_q,  ev_valid_d;
  logic [2:0]    ev_addr_q,   ev_addr_d;
  logic [DW-1:0] ev_data_q,   ev_data_d;
  logic [DW-1:0] ev_mask_q,   ev_mask_d;
  logic          scan_done_q, scan_done_d;
  logic          snap_we;
  logic          complete;

  logic [DW-1:0] snap_q [NUM_BOARDS];
  logic [DW-1:0] snap_cur;

  assign snap_cur = snap_q[idx_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sample_d    = sample_q;
    ev_valid_d  = ev_valid_q;
    ev_addr_d   = ev_addr_q;
    ev_data_d   = ev_data_q;
    ev_mask_d   = ev_mask_q;
    scan_done_d = 1'b0;
    snap_we     = 1'b0;
    complete    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.scan_en) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_SETTLE: begin
        // Only the bus value in the final settle cycle is captured.
        if (cnt_q == '0) begin
          sample_d = bus.d_in;
          state_d  = ST_COMPARE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_COMPARE: begin
        if (sample_q != snap_cur) begin
          ev_valid_d = 1'b1;
          ev_addr_d  = idx_q;
          ev_data_d  = sample_q;
          ev_mask_d  = sample_q ^ snap_cur;
          state_d    = ST_REPORT;
        end else begin
          complete = 1'b1;
        end
      end
      ST_REPORT: begin
        if (ev_valid_q && bus.ev_ready) begin
          snap_we    = 1'b1;
          ev_valid_d = 1'b0;
          complete   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Board completion: advance select, flag end of pass, continue or park.
    if (complete) begin
      idx_d       = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
      scan_done_d = (idx_q == LAST_IDX);
      cnt_d       = CNT_LOAD;
      state_d     = bus.scan_en ? ST_SETTLE : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sample_q    <= '0;
      ev_valid_q  <= 1'b0;
      ev_addr_q   <= '0;
      ev_data_q   <= '0;
      ev_mask_q   <= '0;
      scan_done_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_BOARDS; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sample_q    <= sample_d;
      ev_valid_q  <= ev_valid_d;
      ev_addr_q   <= ev_addr_d;
      ev_data_q   <= ev_data_d;
      ev_mask_q   <= ev_mask_d;
      scan_done_q <= scan_done_d;
      if (snap_we) begin
        snap_q[idx_q] <= ev_data_q;
      end
    end
  end

  assign bus.aBus      = idx_q;
  assign bus.ev_valid  = ev_valid_q;
  assign bus.ev_addr   = ev_addr_q;
  assign bus.ev_data   = ev_data_q;
  assign bus.ev_mask   = ev_mask_q;
  assign bus.scan_done = scan_done_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debounce_bus_scanner.sv
// -----------------------------------------------------------------------------
// tb_debounce_bus_scanner
// Directed bench for debounce_bus_scanner with an abstract board-visit model
// (each visit: SETTLE settle cycles, one decision cycle, then reporting until
// accepted) checked against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_debounce_bus_scanner;

  localparam int NB = 8;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  debounce_bus_scanner_if #(.DW(8)) bus ();

  debounce_bus_scanner #(.NUM_BOARDS(NB), .SETTLE(ST), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] board [NB];
  logic       force_en;
  logic [7:0] force_val;

  assign bus.d_in = force_en ? force_val : board[bus.aBus];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic            busy;
    logic [2:0]      idx;
    logic [31:0]     k;       // cycles spent on the current board visit
    logic            valid;
    logic [2:0]      addr;
    logic [7:0]      data;
    logic [7:0]      mask;
    logic [7:0]      sample;
    logic            done;
    logic [7:0][7:0] snap;
  } mdl_t;

  mdl_t m = '0;

  function automatic mdl_t step(input mdl_t s, input logic en, input logic rdy,
                                input logic [7:0] din);
    mdl_t n = s;
    logic fin = 1'b0;
    n.done = 1'b0;
    if (!s.busy) begin
      if (en) begin
        n.busy = 1'b1;
        n.k    = 0;
      end
    end else if (s.k < 32'(ST)) begin
      if (s.k == 32'(ST - 1)) n.sample = din;
      n.k = s.k + 1;
    end else if (s.k == 32'(ST)) begin
      if (s.sample != s.snap[s.idx]) begin
        n.valid = 1'b1;
        n.addr  = s.idx;
        n.data  = s.sample;
        n.mask  = s.sample ^ s.snap[s.idx];
        n.k     = s.k + 1;
      end else begin
        fin = 1'b1;
      end
    end else if (rdy) begin
      n.snap[s.idx] = s.data;
      n.valid       = 1'b0;
      fin           = 1'b1;
    end
    if (fin) begin
      n.done = (s.idx == 3'(NB - 1));
      n.idx  = (s.idx == 3'(NB - 1)) ? 3'd0 : 3'(s.idx + 3'd1);
      n.k    = 0;
      n.busy = en;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, bus.scan_en, bus.ev_ready,
                          force_en ? force_val : board[m.idx]);
  end

  // ---------------- compare process + event log ----------------
  logic [18:0] ev_log [$];

  always @(negedge clk) begin
    check("aBus",      32'(bus.aBus),      32'(m.idx));
    check("busy",      32'(bus.busy),      32'(m.busy));
    check("ev_valid",  32'(bus.ev_valid),  32'(m.valid));
    check("ev_addr",   32'(bus.ev_addr),   32'(m.addr));
    check("ev_data",   32'(bus.ev_data),   32'(m.data));
    check("ev_mask",   32'(bus.ev_mask),   32'(m.mask));
    check("scan_done", 32'(bus.scan_done), 32'(m.done));
    if (bus.ev_valid && bus.ev_ready)
      ev_log.push_back({bus.ev_addr, bus.ev_data, bus.ev_mask});
  end

  // ---------------- helpers ----------------
  function automatic logic cond(input int which, input logic [2:0] v);
    case (which)
      0:       return bus.scan_done;
      1:       return bus.ev_valid;
      2:       return bus.aBus == v;
      default: return !bus.busy;
    endcase
  endfunction

  task automatic wait_cond(input int which, input logic [2:0] v, input int maxc,
                           input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(which, v) && n < maxc);
    check(name, 32'(cond(which, v)), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_aBus"},     32'(bus.aBus),      32'd0);
    check({tag, "_busy"},     32'(bus.busy),      32'd0);
    check({tag, "_valid"},    32'(bus.ev_valid),  32'd0);
    check({tag, "_addr"},     32'(bus.ev_addr),   32'd0);
    check({tag, "_data"},     32'(bus.ev_data),   32'd0);
    check({tag, "_mask"},     32'(bus.ev_mask),   32'd0);
    check({tag, "_done"},     32'(bus.scan_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    rst_n        = 1'b0;
    bus.scan_en  = 1'b0;
    bus.ev_ready = 1'b0;
    force_en     = 1'b0;
    force_val    = 8'h00;
    for (int i = 0; i < NB; i++) board[i] = 8'h00;
    board[0] = 8'hA5;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");

    @(posedge clk); #1;
    rst_n        = 1'b1;
    bus.scan_en  = 1'b1;
    bus.ev_ready = 1'b1;

    // Pass 1: only board 0 differs from the zero snapshots.
    wait_cond(0, 3'd0, 100, "pass1_done", n);
    check("pass1_cycles", 32'(n), 32'd43);
    check("pass1_events", 32'(ev_log.size()), 32'd1);
    if (ev_log.size() >= 1) check("pass1_ev0", 32'(ev_log[0]), 32'({3'd0, 8'hA5, 8'hA5}));

    // Pass 2: nothing changed, 8 boards x (SETTLE+1).
    wait_cond(0, 3'd0, 100, "pass2_done", n);
    check("pass2_cycles", 32'(n), 32'd40);
    check("pass2_events", 32'(ev_log.size()), 32'd1);

    // Board 3 changes; consumer stalls 10 cycles.
    board[3] = 8'h3C;
    @(posedge clk); #1;
    bus.ev_ready = 1'b0;
    wait_cond(1, 3'd0, 60, "b3_valid", n);
    for (int i = 0; i < 10; i++) begin
      check("b3_hold_valid", 32'(bus.ev_valid), 32'd1);
      check("b3_hold_addr",  32'(bus.ev_addr),  32'd3);
      check("b3_hold_data",  32'(bus.ev_data),  32'h3C);
      check("b3_hold_mask",  32'(bus.ev_mask),  32'h3C);
      check("b3_hold_aBus",  32'(bus.aBus),     32'd3);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.ev_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("b3_after_aBus",  32'(bus.aBus),     32'd4);
    check("b3_after_valid", 32'(bus.ev_valid), 32'd0);
    check("b3_events", 32'(ev_log.size()), 32'd2);
    if (ev_log.size() >= 2) check("b3_ev", 32'(ev_log[1]), 32'({3'd3, 8'h3C, 8'h3C}));

    // Board 5: snapshot 0F, then a single-bit drop to 0E.
    board[5] = 8'h0F;
    wait_cond(0, 3'd0, 100, "pass3_done", n);
    check("pass3_events", 32'(ev_log.size()), 32'd3);
    if (ev_log.size() >= 3) check("b5_ev0F", 32'(ev_log[2]), 32'({3'd5, 8'h0F, 8'h0F}));
    board[5] = 8'h0E;
    wait_cond(0, 3'd0, 100, "pass4_done", n);
    check("pass4_events", 32'(ev_log.size()), 32'd4);
    if (ev_log.size() >= 4) check("b5_ev0E", 32'(ev_log[3]), 32'({3'd5, 8'h0E, 8'h01}));
    wait_cond(0, 3'd0, 100, "pass5_done", n);
    check("pass5_events", 32'(ev_log.size()), 32'd4);

    // Drop scan_en while board 2 settles.
    wait_cond(2, 3'd2, 60, "reach_b2", n);
    @(posedge clk); #1;
    bus.scan_en = 1'b0;
    wait_cond(3, 3'd0, 30, "stop_idle", n);
    for (int i = 0; i < 3; i++) begin
      check("stop_aBus", 32'(bus.aBus), 32'd3);
      check("stop_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
    end
    board[3] = 8'h99;
    @(posedge clk); #1;
    bus.scan_en = 1'b1;
    wait_cond(1, 3'd0, 30, "resume_valid", n);
    check("resume_addr", 32'(bus.ev_addr), 32'd3);
    check("resume_data", 32'(bus.ev_data), 32'h99);
    check("resume_mask", 32'(bus.ev_mask), 32'hA5);
    @(posedge clk); #1;
    bus.ev_ready = 1'b0;

    // Board 6: bus glitches during settle, 55 only in the final cycle.
    wait_cond(2, 3'd6, 60, "reach_b6", n);
    force_en  = 1'b1;
    force_val = 8'h12;
    @(posedge clk); #1; force_val = 8'h34;
    @(posedge clk); #1; force_val = 8'hAA;
    @(posedge clk); #1; force_val = 8'h55;
    @(posedge clk); #1; force_en  = 1'b0;
    wait_cond(1, 3'd0, 30, "b6_valid", n);
    check("b6_addr", 32'(bus.ev_addr), 32'd6);
    check("b6_data", 32'(bus.ev_data), 32'h55);
    check("b6_mask", 32'(bus.ev_mask), 32'h55);

    // Asynchronous reset while the event is pending.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    @(posedge clk); #1;
    rst_n        = 1'b1;
    bus.ev_ready = 1'b1;
    ev_log.delete();

    // Snapshots were cleared: every nonzero board reports again.
    wait_cond(0, 3'd0, 100, "pass6_done", n);
    check("pass6_events", 32'(ev_log.size()), 32'd3);
    if (ev_log.size() == 3) begin
      check("pass6_ev0", 32'(ev_log[0]), 32'({3'd0, 8'hA5, 8'hA5}));
      check("pass6_ev1", 32'(ev_log[1]), 32'({3'd3, 8'h99, 8'h99}));
      check("pass6_ev2", 32'(ev_log[2]), 32'({3'd5, 8'h0E, 8'h0E}));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_bus_scanner.md
Name: debounce_bus_scanner

Overview:
- Host-side reader for the addressable debouncer bus.
- Drives the 3-bit address bus (aBus) to select one debouncer board at a time, waits for the shared 8-bit data bus to settle, then samples it.
- Compares each sample with the last accepted snapshot for that board and emits change events over a valid/ready handshake.
- Sits between the debouncer boards and the system event logic or CPU.

Parameters:
- NUM_BOARDS, 8, number of boards polled; addresses 0..NUM_BOARDS-1; legal range 1..8.
- SETTLE, 4, cycles aBus is held before sampling; minimum 1.
- DW, 8, data bus width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- scan_en  in  1  level; 1 = keep scanning.
- d_in  in  DW  shared data bus from the boards (the out bus of the selected board).
- aBus  out  3  board select; true-polarity address (board straps are inverted pull-ups, so the board itself handles polarity).
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event.
- ev_addr  out  3  board index of the event.
- ev_data  out  DW  new sampled value.
- ev_mask  out  DW  changed bits: sample XOR previous snapshot.
- scan_done  out  1  one-cycle pulse when the last board finishes.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; idx=0, so aBus=0.
  - ev_valid=0, ev_addr=0, ev_data=0, ev_mask=0, scan_done=0, busy=0.
  - All NUM_BOARDS snapshots=0.
  - Reset asserted mid-operation aborts immediately, including in REPORT.
- aBus is the registered idx. It changes only when a board completes.
- States:
  - IDLE: if scan_en=1, go to SETTLE and load cnt=SETTLE-1.
  - SETTLE: decrement cnt. In the cycle cnt==0, register sample<=d_in and go to COMPARE. Only d_in in that final SETTLE cycle matters.
  - COMPARE (1 cycle):
    - If sample != snap[idx]: load ev_addr=idx, ev_data=sample, ev_mask=sample^snap[idx], set ev_valid=1, go to REPORT.
    - Otherwise complete the board.
  - REPORT: ev_valid and all ev_* fields stay stable until ev_valid&&ev_ready at a clock edge. On that edge: snap[idx]<=ev_data, ev_valid<=0, complete the board. No timeout; aBus holds.
- Complete board:
  - idx wraps to 0 after NUM_BOARDS-1, otherwise increments.
  - On wrap, scan_done=1 for exactly one cycle, coincident with the aBus update.
  - Then go to SETTLE (cnt reloaded) if scan_en=1, else IDLE.
- Snapshots update only on handshake acceptance, so an unaccepted change cannot be lost.
- scan_en deasserted mid-board: the current board finishes (including REPORT), then the block goes IDLE with aBus=next idx. Re-enable resumes at that idx.
- ev_mask/ev_data never change while ev_valid=1.
- ev_ready while ev_valid=0 is ignored.
- Timing per board:
  - No change: SETTLE+1 cycles.
  - Change with ev_ready tied high: SETTLE+2 cycles (ev_valid high exactly 1 cycle).
- First pass after reset compares against 0, so every board with nonzero data reports once.

Test Plan:
- Assert rst_n=0 mid-run -> all outputs 0 immediately, aBus=0, busy=0.
- NUM_BOARDS=8, SETTLE=4, bench muxes d_in by aBus; board0=8'hA5, others 8'h00; scan_en=1, ev_ready=1 -> exactly one event (addr 0, data A5, mask A5). scan_done pulses after board 7. Second pass produces no events and takes 40 cycles.
- Board3 changes to 8'h3C; hold ev_ready=0 for 10 cycles -> ev_valid held, fields (3, 3C, 3C) stable, aBus=3. Raise ev_ready -> one accept, then aBus=4.
- Board5 snapshot 8'h0F, d_in becomes 8'h0E -> event addr 5, data 0E, mask 01. Next pass: no event for board5.
- Drop scan_en during SETTLE of board2 -> board2 completes, block goes IDLE with aBus=3, busy=0. Re-enable -> next sample is from board3.
- Toggle d_in during the first 3 SETTLE cycles, stable 8'h55 in the final cycle -> ev_data=55. Then async reset during REPORT -> ev_valid drops at once, and the next pass re-reports all nonzero boards.
